// File: rtl/stopwatch_timer.sv
// MM:SS up/down stopwatch with preset load, lap freeze, countdown expiry and
// wrap/saturate overflow; drives a packed BCD bus and four seven-segment digits.
module stopwatch_timer #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned MAX_MIN  = 59,
   parameter bit          WRAP     = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_stop,
   input  logic        mode,
   input  logic        load,
   input  logic [15:0] preset,
   input  logic        lap,
   output logic        running,
   output logic        expired,
   output logic        overflow,
   output logic        load_err,
   output logic        lap_active,
   output logic [15:0] bcd_out,
   output logic [6:0]  seg3,
   output logic [6:0]  seg2,
   output logic [6:0]  seg1,
   output logic [6:0]  seg0
);

   localparam int unsigned   PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0]    MAX_MT     = 4'(MAX_MIN / 10);
   localparam logic [3:0]    MAX_MO     = 4'(MAX_MIN % 10);

   typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [15:0]   live_q, live_d, snap_q, snap_d, disp_q, disp_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          dir_q, dir_d, lap_q, lap_d, exp_q, exp_d;
   logic          ovf_q, ovf_d, lerr_q, lerr_d;
   logic          tick, up_ovf, preset_ok, load_ok;
   logic [15:0]   up_val, dn_val;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   assign tick = (state_q == RUNNING) && (presc_q == PRESC_LAST);

   assign preset_ok = (preset[15:12] <= 4'd9) && (preset[11:8] <= 4'd9) &&
                      (preset[7:4] <= 4'd5) && (preset[3:0] <= 4'd9) &&
                      ((preset[15:12] < MAX_MT) ||
                       ((preset[15:12] == MAX_MT) && (preset[11:8] <= MAX_MO)));

   // BCD increment/decrement of the live time with carry and borrow chains
   always_comb begin : count_math
      up_val = live_q;
      up_ovf = 1'b0;
      if (live_q[3:0] != 4'd9) begin
         up_val[3:0] = live_q[3:0] + 4'd1;
      end else begin
         up_val[3:0] = 4'd0;
         if (live_q[7:4] != 4'd5) begin
            up_val[7:4] = live_q[7:4] + 4'd1;
         end else begin
            up_val[7:4] = 4'd0;
            if (live_q[15:8] == {MAX_MT, MAX_MO}) begin
               up_ovf = 1'b1;
               up_val = WRAP ? 16'h0000 : live_q;
            end else if (live_q[11:8] != 4'd9) begin
               up_val[11:8] = live_q[11:8] + 4'd1;
            end else begin
               up_val[11:8]  = 4'd0;
               up_val[15:12] = live_q[15:12] + 4'd1;
            end
         end
      end

      dn_val = live_q;
      if (live_q != 16'h0000) begin
         if (live_q[3:0] != 4'd0) begin
            dn_val[3:0] = live_q[3:0] - 4'd1;
         end else begin
            dn_val[3:0] = 4'd9;
            if (live_q[7:4] != 4'd0) begin
               dn_val[7:4] = live_q[7:4] - 4'd1;
            end else begin
               dn_val[7:4] = 4'd5;
               if (live_q[11:8] != 4'd0) begin
                  dn_val[11:8] = live_q[11:8] - 4'd1;
               end else begin
                  dn_val[11:8]  = 4'd9;
                  dn_val[15:12] = live_q[15:12] - 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin : state_reg
      if (reset) begin
         state_q <= STOPPED;
         live_q  <= '0;
         snap_q  <= '0;
         disp_q  <= '0;
         presc_q <= '0;
         dir_q   <= 1'b0;
         lap_q   <= 1'b0;
         exp_q   <= 1'b0;
         ovf_q   <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= live_d;
         snap_q  <= snap_d;
         disp_q  <= disp_d;
         presc_q <= presc_d;
         dir_q   <= dir_d;
         lap_q   <= lap_d;
         exp_q   <= exp_d;
         ovf_q   <= ovf_d;
         lerr_q  <= lerr_d;
      end
   end

   // Priority below reset: tick > start_stop > load > lap
   always_comb begin : next_state
      state_d = state_q;
      live_d  = live_q;
      snap_d  = snap_q;
      presc_d = presc_q;
      dir_d   = dir_q;
      lap_d   = lap_q;
      exp_d   = exp_q;
      ovf_d   = 1'b0;
      lerr_d  = 1'b0;
      load_ok = 1'b0;

      if (state_q == RUNNING) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            if (dir_q) begin
               live_d = dn_val;
               if (dn_val == 16'h0000) begin
                  exp_d   = 1'b1;
                  state_d = STOPPED;
               end
            end else begin
               live_d = up_val;
               if (up_ovf) begin
                  ovf_d = 1'b1;
                  if (!WRAP) state_d = STOPPED;
               end
            end
         end
         if (start_stop) state_d = STOPPED;
         if (load) lerr_d = 1'b1;
      end else if (start_stop && !(mode && (live_q == 16'h0000))) begin
         state_d = RUNNING;
         dir_d   = mode;
         presc_d = '0;
         exp_d   = 1'b0;
         if (load) lerr_d = 1'b1;
      end else if (load) begin
         if (preset_ok) begin
            load_ok = 1'b1;
            live_d  = preset;
            exp_d   = 1'b0;
            presc_d = '0;
            lap_d   = 1'b0;
         end else begin
            lerr_d = 1'b1;
         end
      end

      // Snapshot takes the pre-tick time
      if (lap && !load_ok) begin
         if (lap_q) begin
            lap_d = 1'b0;
         end else begin
            lap_d  = 1'b1;
            snap_d = live_q;
         end
      end

      disp_d = lap_d ? snap_d : live_d;
   end

   always_comb begin : outputs
      running    = (state_q == RUNNING);
      expired    = exp_q;
      overflow   = ovf_q;
      load_err   = lerr_q;
      lap_active = lap_q;
      bcd_out    = disp_q;
      seg3       = seg7(disp_q[15:12]);
      seg2       = seg7(disp_q[11:8]);
      seg1       = seg7(disp_q[7:4]);
      seg0       = seg7(disp_q[3:0]);
   end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: three configurations driven in lockstep and compared
// every cycle against a seconds-based reference model, plus directed checks.
module tb_stopwatch_timer;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset, start_stop, mode, load, lap;
   logic [15:0] preset;

   logic        r_running[3], r_expired[3], r_overflow[3], r_load_err[3], r_lap[3];
   logic [15:0] r_bcd[3];
   logic [6:0]  r_seg3[3], r_seg2[3], r_seg1[3], r_seg0[3];

   int total = 0;
   int bad   = 0;

   int m_secs[3], m_phase[3], m_snap[3];
   bit m_run[3], m_dir[3], m_exp[3], m_ovf[3], m_lerr[3], m_lap[3];

   always #5 clk = ~clk;

   stopwatch_timer #(.TICK_DIV(TD), .MAX_MIN(1), .WRAP(1'b1)) u_wrap (
      .clk(clk), .reset(reset), .start_stop(start_stop), .mode(mode), .load(load),
      .preset(preset), .lap(lap), .running(r_running[0]), .expired(r_expired[0]),
      .overflow(r_overflow[0]), .load_err(r_load_err[0]), .lap_active(r_lap[0]),
      .bcd_out(r_bcd[0]), .seg3(r_seg3[0]), .seg2(r_seg2[0]), .seg1(r_seg1[0]),
      .seg0(r_seg0[0]));

   stopwatch_timer #(.TICK_DIV(TD), .MAX_MIN(1), .WRAP(1'b0)) u_sat (
      .clk(clk), .reset(reset), .start_stop(start_stop), .mode(mode), .load(load),
      .preset(preset), .lap(lap), .running(r_running[1]), .expired(r_expired[1]),
      .overflow(r_overflow[1]), .load_err(r_load_err[1]), .lap_active(r_lap[1]),
      .bcd_out(r_bcd[1]), .seg3(r_seg3[1]), .seg2(r_seg2[1]), .seg1(r_seg1[1]),
      .seg0(r_seg0[1]));

   stopwatch_timer #(.TICK_DIV(TD), .MAX_MIN(59), .WRAP(1'b1)) u_hour (
      .clk(clk), .reset(reset), .start_stop(start_stop), .mode(mode), .load(load),
      .preset(preset), .lap(lap), .running(r_running[2]), .expired(r_expired[2]),
      .overflow(r_overflow[2]), .load_err(r_load_err[2]), .lap_active(r_lap[2]),
      .bcd_out(r_bcd[2]), .seg3(r_seg3[2]), .seg2(r_seg2[2]), .seg1(r_seg1[2]),
      .seg0(r_seg0[2]));

   function automatic int lim(int i);
      return ((i == 2) ? 59 : 1) * 60 + 59;
   endfunction

   function automatic bit wraps(int i);
      return i != 1;
   endfunction

   function automatic logic [15:0] to_bcd(int secs);
      int m, s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [6:0] seg_of(logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic bit preset_valid(logic [15:0] p, int i);
      int mins;
      mins = int'(p[15:12]) * 10 + int'(p[11:8]);
      return (p[15:12] <= 4'd9) && (p[11:8] <= 4'd9) && (p[7:4] <= 4'd5) &&
             (p[3:0] <= 4'd9) && (mins * 60 + 59 <= lim(i));
   endfunction

   function automatic int preset_secs(logic [15:0] p);
      return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
   endfunction

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour in whole seconds, advanced once per clock edge
   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int old_secs;
         bit ld_ok;
         old_secs = m_secs[i];
         ld_ok    = 1'b0;
         if (reset) begin
            m_secs[i] = 0; m_phase[i] = 0; m_snap[i] = 0;
            m_run[i] = 0; m_dir[i] = 0; m_exp[i] = 0;
            m_ovf[i] = 0; m_lerr[i] = 0; m_lap[i] = 0;
         end else begin
            m_ovf[i]  = 0;
            m_lerr[i] = 0;
            if (m_run[i]) begin
               if (m_phase[i] == TD - 1) begin
                  m_phase[i] = 0;
                  if (m_dir[i]) begin
                     if (m_secs[i] > 0) m_secs[i]--;
                     if (m_secs[i] == 0) begin m_exp[i] = 1; m_run[i] = 0; end
                  end else if (m_secs[i] >= lim(i)) begin
                     m_ovf[i] = 1;
                     if (wraps(i)) m_secs[i] = 0;
                     else m_run[i] = 0;
                  end else begin
                     m_secs[i]++;
                  end
               end else begin
                  m_phase[i]++;
               end
               if (start_stop) m_run[i] = 0;
               if (load) m_lerr[i] = 1;
            end else if (start_stop && !(mode && m_secs[i] == 0)) begin
               m_run[i] = 1; m_dir[i] = mode; m_phase[i] = 0; m_exp[i] = 0;
               if (load) m_lerr[i] = 1;
            end else if (load) begin
               if (preset_valid(preset, i)) begin
                  ld_ok = 1'b1;
                  m_secs[i] = preset_secs(preset);
                  m_exp[i] = 0; m_phase[i] = 0; m_lap[i] = 0;
               end else begin
                  m_lerr[i] = 1;
               end
            end
            if (lap && !ld_ok) begin
               if (m_lap[i]) m_lap[i] = 0;
               else begin m_lap[i] = 1; m_snap[i] = old_secs; end
            end
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         logic [15:0] eb;
         eb = to_bcd(m_lap[i] ? m_snap[i] : m_secs[i]);
         chk($sformatf("running%0d", i),  16'(r_running[i]),  16'(m_run[i]));
         chk($sformatf("expired%0d", i),  16'(r_expired[i]),  16'(m_exp[i]));
         chk($sformatf("overflow%0d", i), 16'(r_overflow[i]), 16'(m_ovf[i]));
         chk($sformatf("load_err%0d", i), 16'(r_load_err[i]), 16'(m_lerr[i]));
         chk($sformatf("lap%0d", i),      16'(r_lap[i]),      16'(m_lap[i]));
         chk($sformatf("bcd%0d", i),      r_bcd[i],           eb);
         chk($sformatf("seg3_%0d", i),    16'(r_seg3[i]),     16'(seg_of(eb[15:12])));
         chk($sformatf("seg2_%0d", i),    16'(r_seg2[i]),     16'(seg_of(eb[11:8])));
         chk($sformatf("seg1_%0d", i),    16'(r_seg1[i]),     16'(seg_of(eb[7:4])));
         chk($sformatf("seg0_%0d", i),    16'(r_seg0[i]),     16'(seg_of(eb[3:0])));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      reset = 1'b0; start_stop = 1'b0; load = 1'b0; lap = 1'b0;
   endtask

   task automatic step(int n);
      repeat (n) cyc();
   endtask

   initial begin
      reset = 1'b1; start_stop = 1'b0; mode = 1'b0; load = 1'b0; lap = 1'b0;
      preset = 16'h0000;
      cyc();
      chk("rst_bcd", r_bcd[0], 16'h0000);
      chk("rst_seg3", 16'(r_seg3[0]), 16'h003F);
      chk("rst_run", 16'(r_running[0]), 16'h0000);

      // count up through carries and the overflow boundary
      start_stop = 1'b1; mode = 1'b0; cyc();
      step(40);
      chk("up_0010", r_bcd[0], 16'h0010);
      step(200);
      chk("up_0100", r_bcd[0], 16'h0100);
      step(236);
      chk("up_0159", r_bcd[0], 16'h0159);
      step(4);
      chk("wrap_ovf", 16'(r_overflow[0]), 16'h0001);
      chk("wrap_bcd", r_bcd[0], 16'h0000);
      chk("wrap_run", 16'(r_running[0]), 16'h0001);
      chk("sat_ovf", 16'(r_overflow[1]), 16'h0001);
      chk("sat_bcd", r_bcd[1], 16'h0159);
      chk("sat_run", 16'(r_running[1]), 16'h0000);
      chk("hour_bcd", r_bcd[2], 16'h0200);
      step(1);
      chk("ovf_pulse", 16'(r_overflow[0]), 16'h0000);

      // countdown to expiry
      reset = 1'b1; cyc();
      preset = 16'h0102; load = 1'b1; cyc();
      chk("cd_load", r_bcd[0], 16'h0102);
      start_stop = 1'b1; mode = 1'b1; cyc();
      step(8);
      chk("cd_0100", r_bcd[0], 16'h0100);
      step(4);
      chk("cd_0059", r_bcd[0], 16'h0059);
      step(236);
      chk("cd_zero", r_bcd[0], 16'h0000);
      chk("cd_exp", 16'(r_expired[0]), 16'h0001);
      chk("cd_run", 16'(r_running[0]), 16'h0000);
      start_stop = 1'b1; mode = 1'b1; cyc();
      chk("cd_refuse_run", 16'(r_running[0]), 16'h0000);
      chk("cd_refuse_exp", 16'(r_expired[0]), 16'h0001);

      // load acceptance rules
      preset = 16'h0060; load = 1'b1; cyc();
      chk("ld_bad_err", 16'(r_load_err[2]), 16'h0001);
      chk("ld_bad_bcd", r_bcd[2], 16'h0000);
      cyc();
      chk("ld_err_pulse", 16'(r_load_err[2]), 16'h0000);
      preset = 16'h0530; load = 1'b1; cyc();
      chk("ld_ok_bcd", r_bcd[2], 16'h0530);
      chk("ld_ok_seg3", 16'(r_seg3[2]), 16'h003F);
      chk("ld_ok_seg2", 16'(r_seg2[2]), 16'h006D);
      chk("ld_ok_seg1", 16'(r_seg1[2]), 16'h004F);
      chk("ld_ok_seg0", 16'(r_seg0[2]), 16'h003F);
      chk("ld_min_err", 16'(r_load_err[0]), 16'h0001);
      start_stop = 1'b1; mode = 1'b0; cyc();
      step(2);
      preset = 16'h0010; load = 1'b1; cyc();
      chk("ld_run_err", 16'(r_load_err[2]), 16'h0001);
      chk("ld_run_bcd", r_bcd[2], 16'h0530);

      // lap freeze, release and coincidence with a tick
      reset = 1'b1; cyc();
      start_stop = 1'b1; mode = 1'b0; cyc();
      step(20);
      lap = 1'b1; cyc();
      chk("lap_on", 16'(r_lap[0]), 16'h0001);
      step(11);
      chk("lap_hold", r_bcd[0], 16'h0005);
      lap = 1'b1; cyc();
      chk("lap_off", r_bcd[0], 16'h0008);
      step(2);
      lap = 1'b1; cyc();
      chk("lap_tick", r_bcd[0], 16'h0008);
      lap = 1'b1; cyc();
      chk("lap_live", r_bcd[0], 16'h0009);

      // reset mid-run dominates start_stop and load
      step(5);
      reset = 1'b1; start_stop = 1'b1; load = 1'b1; preset = 16'h0130; cyc();
      chk("rr_run", 16'(r_running[0]), 16'h0000);
      chk("rr_bcd", r_bcd[0], 16'h0000);
      chk("rr_seg0", 16'(r_seg0[0]), 16'h003F);
      start_stop = 1'b1; mode = 1'b0; cyc();
      step(3);
      chk("rr_pre", r_bcd[0], 16'h0000);
      step(1);
      chk("rr_tick", r_bcd[0], 16'h0001);

      // randomized control traffic
      for (int n = 0; n < 1500; n++) begin
         int r;
         r = int'($urandom_range(99));
         if (r < 2) begin
            reset = 1'b1;
         end else if (r < 8) begin
            start_stop = 1'b1;
            mode = 1'($urandom_range(1));
         end else if (r < 13) begin
            load = 1'b1;
            if ($urandom_range(1) == 0) preset = 16'($urandom);
            else preset = {8'h00, 4'($urandom_range(5)), 4'($urandom_range(9))};
         end else if (r < 17) begin
            lap = 1'b1;
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_timer.md
# stopwatch_timer

Parametrised four-digit MM:SS up/down stopwatch with preset load, lap hold, countdown expiry and wrap/saturate overflow handling. It drives four seven-segment digits plus a packed BCD bus. It sits between the board push-button conditioners, which deliver single-cycle pulses, and the display mux. It is the next-generation replacement for the fixed up-only timer.

## Interface
- TICK_DIV, 50_000_000: clk cycles per one-second count tick. Legal range is 2..2^26.
- MAX_MIN, 59: highest minute value, 1..99. Count-up overflow occurs past MAX_MIN:59.
- WRAP, 1: 1 = count-up wraps to 00:00 and continues; 0 = saturate at MAX_MIN:59 and stop.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; highest priority.
- start_stop  in  1  single-cycle pulse; toggles run state.
- mode  in  1  0 = count up, 1 = count down; sampled only on a start pulse.
- load  in  1  single-cycle pulse; loads preset when stopped.
- preset  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
- lap  in  1  single-cycle pulse; toggles display freeze.
- running  out  1  run state.
- expired  out  1  sticky; countdown reached 00:00.
- overflow  out  1  single-cycle pulse on count-up past MAX_MIN:59.
- load_err  out  1  single-cycle pulse when load is rejected.
- lap_active  out  1  display frozen.
- bcd_out  out  16  displayed time, same packing as preset.
- seg3, seg2, seg1, seg0  out  7 each  seven-segment patterns for min_tens..sec_ones. Bit 0 = a through bit 6 = g; 1 = lit. Digit patterns 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F. Non-BCD input gives 00.

## Operation
- Internal state:
  - live time: four BCD digits.
  - prescaler: 0..TICK_DIV-1.
  - dir: latched mode.
  - run, lap snapshot, expired.
- Run state machine has two states, STOPPED and RUNNING.
  - start_stop in STOPPED enters RUNNING, latches dir = mode and clears prescaler. It also clears expired, except as below.
  - start_stop in STOPPED is refused if mode = 1 and live time = 00:00. State stays STOPPED and expired is unchanged.
  - start_stop in RUNNING enters STOPPED. The prescaler holds its value and live time holds.
- Prescaler increments only in RUNNING. At TICK_DIV-1 it returns to 0 and a tick fires.
- Count up on a tick:
  - sec_ones 9 -> 0 carries to sec_tens.
  - sec_tens 5 -> 0 carries to minutes.
  - Minutes are a 2-digit BCD value incrementing 0..MAX_MIN.
  - Past MAX_MIN:59, overflow pulses. If WRAP=1, live time becomes 00:00 and counting continues. If WRAP=0, live time stays MAX_MIN:59 and the block enters STOPPED.
- Count down on a tick:
  - Borrow rules mirror count-up; sec_tens 0 -> 5 on borrow.
  - A tick from 00:01 yields 00:00, sets expired and enters STOPPED.
- Load:
  - Applies only in STOPPED. preset overwrites live time, clears expired and clears prescaler.
  - A load is rejected, pulsing load_err with live time unchanged, if any of these hold: any digit > 9, sec_tens > 5, preset minutes > MAX_MIN, or the block is RUNNING.
- Lap:
  - A lap pulse with lap_active=0 copies live time to the snapshot and sets lap_active.
  - A lap pulse with lap_active=1 clears lap_active.
  - Counting is unaffected by lap. reset and load also clear lap_active.
- Display value = lap_active ? snapshot : live time. It drives bcd_out; seg outputs are a combinational decode of bcd_out.

## Timing
- Reset values:
  - time 00:00, prescaler 0, STOPPED, dir 0.
  - running 0, expired 0, overflow 0, load_err 0, lap_active 0.
  - bcd_out 16'h0000; all seg = 7'h3F.
- All state is registered on posedge clk. Outputs reflect a state change on the cycle after the causing edge.
- First tick after start: TICK_DIV cycles after the start pulse edge. Subsequent ticks follow every TICK_DIV cycles.
- overflow and load_err are high for exactly one cycle. expired holds until a start, load or reset.
- Same-cycle priority, highest first: reset > tick > start_stop > load > lap.
  - Tick and stop in the same cycle: the count applies, then the block stops.
  - Tick and lap in the same cycle: the snapshot captures the pre-tick value.
  - A countdown that expires and a start_stop in the same cycle: the block ends STOPPED with expired=1.
- reset mid-run: all state returns to reset values on that edge, regardless of other inputs.

## Test plan
- Count up: TICK_DIV=4, MAX_MIN=1, WRAP=1. Start, run 120 ticks. Required: 00:09 -> 00:10, 00:59 -> 01:00, then after 01:59 one overflow pulse, 00:00, running=1.
- Saturate: same setup with WRAP=0. Required: after 01:59 the next tick gives overflow, bcd_out=16'h0159, running=0.
- Countdown: load 16'h0102, mode=1, start, 62 ticks. Required: 01:00 -> 00:59. After the final tick, bcd_out=0, expired=1, running=0. A further start is refused.
- Load rules:
  - preset 16'h0060 -> load_err, time unchanged.
  - load while running -> load_err.
  - valid load of 16'h0530 -> bcd_out=16'h0530, seg3=3F, seg2=6D, seg1=4F, seg0=3F.
- Lap: lap at 00:05, run 3 ticks -> bcd_out stays 16'h0005. Second lap -> 16'h0008. Lap coincident with a tick captures the pre-tick value.
- Reset: assert reset mid-run with start_stop and load also high. The next cycle shows all outputs at reset values and the prescaler restarts from 0.
